// File: rtl/reset_sequence_gen_pkg.sv
// Shared encodings and widths for the board reset sequencer.
package reset_sequence_gen_pkg;

    localparam int unsigned SEQ_STATE_W   = 2;
    localparam int unsigned RESET_COUNT_W = 8;
    localparam int unsigned CYCLE_CNT_W   = 32;

    typedef enum logic [SEQ_STATE_W-1:0] {
        HOLD_S    = 2'b00,
        STRETCH_S = 2'b01,
        RUN_S     = 2'b10,
        ILLEGAL_S = 2'b11
    } seq_state_e;

    // Saturating increment for the reset-event counter.
    function automatic logic [RESET_COUNT_W-1:0] sat_inc(input logic [RESET_COUNT_W-1:0] value);
        return (value == {RESET_COUNT_W{1'b1}}) ? value : value + RESET_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/reset_sequence_gen_input_sync_debounce.sv
// Multi-flop synchroniser followed by a stable-level debouncer for one async input.
module input_sync_debounce
    import reset_sequence_gen_pkg::*;
#(
    parameter int unsigned sync_stages     = 2,
    parameter int unsigned debounce_cycles = 32'd1_250_000,
    parameter logic        reset_level     = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_debounced
);

    logic [sync_stages-1:0] sync_q;
    logic [CYCLE_CNT_W-1:0] db_cnt_q;
    logic                   synced;

    assign synced = sync_q[sync_stages-1];

    // Plain flop chain: nothing may sit between the pin and the last stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {sync_stages{reset_level}};
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], i_async};
        end
    end

    // Accept a new level only after it has differed for debounce_cycles consecutive cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            db_cnt_q    <= '0;
            o_debounced <= reset_level;
        end else if (synced == o_debounced) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == CYCLE_CNT_W'(debounce_cycles - 1)) begin
            db_cnt_q    <= '0;
            o_debounced <= synced;
        end else begin
            db_cnt_q <= db_cnt_q + CYCLE_CNT_W'(1);
        end
    end

endmodule

// File: rtl/reset_sequence_gen.sv
// Board reset sequencer: debounced button + PLL lock qualify a stretched active-low system reset.
module reset_sequence_gen
    import reset_sequence_gen_pkg::*;
#(
    parameter int unsigned debounce_cycles = 32'd1_250_000,
    parameter int unsigned stretch_cycles  = 32'd1024,
    parameter int unsigned sync_stages     = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_button_n,
    input  logic                     i_pll_locked,
    output logic                     o_rst_n,
    output logic [SEQ_STATE_W-1:0]   ov_seq_state,
    output logic [RESET_COUNT_W-1:0] ov_reset_count
);

    seq_state_e             state_q, state_d;
    logic [CYCLE_CNT_W-1:0] stretch_q, stretch_d;
    logic                   rst_n_d;
    logic [RESET_COUNT_W-1:0] count_d;
    logic [sync_stages-1:0] lock_sync_q;
    logic                   button_db;
    logic                   lock_synced;
    logic                   release_ok_c;

    input_sync_debounce #(
        .sync_stages    (sync_stages),
        .debounce_cycles(debounce_cycles),
        .reset_level    (1'b1)
    ) u_button (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_async    (i_button_n),
        .o_debounced(button_db)
    );

    // Lock is only synchronised: a loss must reach the FSM without debounce delay.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[sync_stages-2:0], i_pll_locked};
        end
    end

    assign lock_synced  = lock_sync_q[sync_stages-1];
    assign release_ok_c = button_db & lock_synced;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= HOLD_S;
            stretch_q      <= '0;
            o_rst_n        <= 1'b0;
            ov_reset_count <= '0;
        end else begin
            state_q        <= state_d;
            stretch_q      <= stretch_d;
            o_rst_n        <= rst_n_d;
            ov_reset_count <= count_d;
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        rst_n_d   = 1'b0;
        count_d   = ov_reset_count;
        unique case (state_q)
            HOLD_S: begin
                stretch_d = '0;
                if (release_ok_c) begin
                    state_d = STRETCH_S;
                end
            end
            STRETCH_S: begin
                if (!release_ok_c) begin
                    state_d   = HOLD_S;
                    stretch_d = '0;
                end else if (stretch_q == CYCLE_CNT_W'(stretch_cycles - 1)) begin
                    state_d   = RUN_S;
                    stretch_d = '0;
                    rst_n_d   = 1'b1;
                end else begin
                    stretch_d = stretch_q + CYCLE_CNT_W'(1);
                end
            end
            RUN_S: begin
                if (!release_ok_c) begin
                    state_d = HOLD_S;
                    count_d = sat_inc(ov_reset_count);
                end else begin
                    rst_n_d = 1'b1;
                end
            end
            default: begin
                state_d   = HOLD_S;
                stretch_d = '0;
            end
        endcase
    end

    assign ov_seq_state = state_q;

endmodule

// File: tb/tb_reset_sequence_gen.sv
// Randomised and directed bench for reset_sequence_gen against a run-length behavioural model.
module tb_reset_sequence_gen;

    localparam int unsigned DB = 8;
    localparam int unsigned ST = 16;
    localparam int unsigned SS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       button_n;
    logic       pll_locked;
    logic       o_rst_n;
    logic [1:0] seq_state;
    logic [7:0] reset_count;

    always #5 clk = ~clk;

    reset_sequence_gen #(
        .debounce_cycles(DB),
        .stretch_cycles (ST),
        .sync_stages    (SS)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_button_n    (button_n),
        .i_pll_locked  (pll_locked),
        .o_rst_n       (o_rst_n),
        .ov_seq_state  (seq_state),
        .ov_reset_count(reset_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit model_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: release is allowed when the debounced button and synced lock are both
    // high; the sequencer is in RUN once 'allowed' has held for ST+1 consecutive edges.
    logic m_bsync [SS];
    logic m_lsync [SS];
    logic m_db;
    logic m_prev_s;
    int   m_stable;
    int   m_run;
    int   m_count;

    always @(posedge clk) begin
        logic allowed;
        logic s;
        if (rst) begin
            for (int i = 0; i < int'(SS); i++) begin
                m_bsync[i] = 1'b1;
                m_lsync[i] = 1'b0;
            end
            m_db     = 1'b1;
            m_prev_s = 1'b1;
            m_stable = 0;
            m_run    = 0;
            m_count  = 0;
        end else begin
            allowed = m_db && m_lsync[SS-1];
            s       = m_bsync[SS-1];
            if (m_stable > 0 && s == m_prev_s) m_stable++;
            else m_stable = 1;
            m_prev_s = s;
            if (s != m_db && m_stable >= int'(DB)) m_db = s;
            if (allowed) begin
                if (m_run < 1_000_000) m_run++;
            end else begin
                if (m_run > int'(ST)) m_count = (m_count < 255) ? m_count + 1 : 255;
                m_run = 0;
            end
            for (int i = int'(SS) - 1; i > 0; i--) begin
                m_bsync[i] = m_bsync[i-1];
                m_lsync[i] = m_lsync[i-1];
            end
            m_bsync[0] = button_n;
            m_lsync[0] = pll_locked;
        end
    end

    // Cycle-by-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (model_en) begin
            check("model_rst_n", int'(o_rst_n), (m_run > int'(ST)) ? 1 : 0);
            check("model_state", int'(seq_state), (m_run == 0) ? 0 : ((m_run > int'(ST)) ? 2 : 1));
            check("model_count", int'(reset_count), m_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rst_n(input logic v, input int limit, input string name, output int n);
        n = 0;
        while (o_rst_n !== v && n < limit) begin
            tick();
            n++;
        end
        check(name, int'(o_rst_n), int'(v));
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, input string name);
        int n;
        n = 0;
        while (seq_state !== s && n < limit) begin
            tick();
            n++;
        end
        check(name, int'(seq_state), int'(s));
    endtask

    initial begin
        int n;
        int prev_state;
        int bh;
        int lh;

        rst        = 1'b1;
        button_n   = 1'b1;
        pll_locked = 1'b1;
        tick();
        model_en = 1'b1;
        repeat (3) tick();
        check("reset_rst_n", int'(o_rst_n), 0);
        check("reset_state", int'(seq_state), 0);
        check("reset_count", int'(reset_count), 0);

        // Power-up: lock already high, release after 2 sync + 1 + 16 stretch edges.
        rst        = 1'b0;
        n          = 0;
        prev_state = int'(seq_state);
        while (o_rst_n !== 1'b1 && n < 100) begin
            prev_state = int'(seq_state);
            tick();
            n++;
        end
        check("powerup_latency", n, 19);
        check("powerup_prev_state", prev_state, 1);
        check("powerup_state", int'(seq_state), 2);
        check("powerup_count", int'(reset_count), 0);

        // Short glitch is rejected.
        button_n = 1'b0;
        repeat (5) tick();
        button_n = 1'b1;
        repeat (20) tick();
        check("glitch_rst_n", int'(o_rst_n), 1);
        check("glitch_count", int'(reset_count), 0);

        // Held press: 2 sync + 8 debounce + 1 edges to reset assertion.
        button_n = 1'b0;
        wait_rst_n(1'b0, 100, "press_timeout", n);
        check("press_latency", n, 11);
        check("press_count", int'(reset_count), 1);
        repeat (9) tick();
        button_n = 1'b1;

        // Lock loss partway through the stretch, then a full restart.
        wait_state(2'b01, 100, "enter_stretch");
        repeat (8) tick();
        pll_locked = 1'b0;
        repeat (6) tick();
        check("lockloss_state", int'(seq_state), 0);
        check("lockloss_rst_n", int'(o_rst_n), 0);
        check("lockloss_count", int'(reset_count), 1);
        pll_locked = 1'b1;
        wait_state(2'b01, 100, "restretch_enter");
        wait_rst_n(1'b1, 100, "restretch_timeout", n);
        check("restretch_len", n, 16);
        check("restretch_count", int'(reset_count), 1);

        // Button and lock loss reach the FSM on the same edge.
        repeat (3) tick();
        button_n = 1'b0;
        repeat (8) tick();
        pll_locked = 1'b0;
        repeat (30) tick();
        check("simul_count", int'(reset_count), 2);
        check("simul_state", int'(seq_state), 0);
        check("simul_rst_n", int'(o_rst_n), 0);
        button_n   = 1'b1;
        pll_locked = 1'b1;

        // Saturation via repeated lock toggling.
        for (int i = 0; i < 260; i++) begin
            wait_rst_n(1'b1, 100, "sat_run", n);
            pll_locked = 1'b0;
            repeat (4) tick();
            pll_locked = 1'b1;
        end
        repeat (2) tick();
        check("sat_count", int'(reset_count), 255);

        // Mid-operation resets in RUN and in STRETCH.
        wait_state(2'b10, 100, "mid_run_enter");
        rst = 1'b1;
        tick();
        check("midrun_rst_n", int'(o_rst_n), 0);
        check("midrun_state", int'(seq_state), 0);
        check("midrun_count", int'(reset_count), 0);
        rst = 1'b0;
        wait_state(2'b01, 100, "mid_stretch_enter");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midstretch_rst_n", int'(o_rst_n), 0);
        check("midstretch_state", int'(seq_state), 0);
        check("midstretch_count", int'(reset_count), 0);
        rst = 1'b0;

        // Random pins with occasional resets; the model is compared every cycle.
        bh = 0;
        lh = 0;
        for (int i = 0; i < 4000; i++) begin
            if (bh == 0) begin
                button_n = ($urandom_range(0, 3) != 0);
                bh = $urandom_range(1, 30);
            end else begin
                bh--;
            end
            if (lh == 0) begin
                pll_locked = ($urandom_range(0, 4) != 0);
                lh = $urandom_range(1, 60);
            end else begin
                lh--;
            end
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
